// File: rtl/lru_set_ctrl.sv
// lru_set_ctrl: per-set 4-way LRU replacement controller.
// Each set holds four 2-bit ages (always a permutation of 0..3, 0 = MRU,
// 3 = LRU) and four valid bits. Requests are serialised through a small FSM:
// IDLE -> READ -> UPDATE -> IDLE, or IDLE -> SWEEP -> IDLE for CLEAR.
// Optional feature macro: LRU_STATS_EN adds saturating touch/alloc/evict
// counters; without it those ports and counters do not exist.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, so at most one request is in flight.
// resp_valid is a single-cycle pulse with no backpressure; resp_way,
// resp_evict and resp_err keep their last values and are only meaningful
// while resp_valid is high.
module lru_set_ctrl #(
    parameter int SET_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [SET_BITS-1:0] req_set,
    input  logic [1:0]          req_way,
    output logic                resp_valid,
    output logic [1:0]          resp_way,
    output logic                resp_evict,
    output logic                resp_err,
    output logic [1:0]          dbg_state
`ifdef LRU_STATS_EN
    ,
    output logic [31:0]         stat_touch,
    output logic [31:0]         stat_alloc,
    output logic [31:0]         stat_evict
`endif
);

    localparam int NUM_SETS = 2 ** SET_BITS;

    localparam logic [1:0] OP_TOUCH = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Reset ages packed as {way3, way2, way1, way0} = {3, 2, 1, 0}.
    localparam logic [7:0] AGE_INIT = 8'hE4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_UPDATE = 2'd2,
        S_SWEEP  = 2'd3
    } state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [SET_BITS-1:0] set_q;
    logic [1:0]          way_q;
    logic [SET_BITS-1:0] sweep_idx;

    // Ages of way i live in bits [2*i+1:2*i].
    logic [7:0] age_mem   [NUM_SETS];
    logic [3:0] valid_mem [NUM_SETS];

    logic [7:0] cur_age;
    logic [3:0] cur_valid;
    logic [7:0] nxt_age;
    logic [3:0] nxt_valid;

    logic [1:0] victim;
    logic [1:0] way_age;
    logic [7:0] c_age;
    logic [3:0] c_valid;
    logic [1:0] c_way;
    logic       c_evict;
    logic       c_err;

    assign cur_age   = age_mem[set_q];
    assign cur_valid = valid_mem[set_q];
    assign dbg_state = state;

    // Make way w the MRU: every way younger than w ages by one.
    function automatic logic [7:0] touch_ages(input logic [7:0] a, input logic [1:0] w);
        logic [7:0] r;
        logic [1:0] aw;
        r  = a;
        aw = a[{w, 1'b0} +: 2];
        for (int i = 0; i < 4; i++) begin
            if (a[2*i +: 2] < aw) r[2*i +: 2] = a[2*i +: 2] + 2'd1;
        end
        r[{w, 1'b0} +: 2] = 2'd0;
        return r;
    endfunction

`ifdef LRU_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
`endif

    // Next age/valid state and response for the set being processed.
    always_comb begin
        victim  = 2'd0;
        way_age = cur_age[{way_q, 1'b0} +: 2];
        c_age   = cur_age;
        c_valid = cur_valid;
        c_way   = way_q;
        c_evict = 1'b0;
        c_err   = 1'b0;

        // Prefer the lowest-index empty way; only evict when the set is full.
        if (&cur_valid) begin
            for (int i = 3; i >= 0; i--) begin
                if (cur_age[2*i +: 2] == 2'd3) victim = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (!cur_valid[i]) victim = 2'(i);
            end
        end

        case (op_q)
            OP_TOUCH: begin
                if (cur_valid[way_q]) c_age = touch_ages(cur_age, way_q);
                else                  c_err = 1'b1;
            end
            OP_ALLOC: begin
                c_way           = victim;
                c_evict         = &cur_valid;
                c_valid[victim] = 1'b1;
                c_age           = touch_ages(cur_age, victim);
            end
            OP_INVAL: begin
                if (cur_valid[way_q]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (cur_age[2*i +: 2] > way_age) c_age[2*i +: 2] = cur_age[2*i +: 2] - 2'd1;
                    end
                    c_age[{way_q, 1'b0} +: 2] = 2'd3;
                    c_valid[way_q]            = 1'b0;
                end else begin
                    c_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control FSM: request capture, response generation, sweep sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            op_q       <= OP_TOUCH;
            set_q      <= '0;
            way_q      <= 2'd0;
            sweep_idx  <= '0;
            nxt_age    <= AGE_INIT;
            nxt_valid  <= 4'd0;
            resp_valid <= 1'b0;
            resp_way   <= 2'd0;
            resp_evict <= 1'b0;
            resp_err   <= 1'b0;
`ifdef LRU_STATS_EN
            stat_touch <= 32'd0;
            stat_alloc <= 32'd0;
            stat_evict <= 32'd0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        set_q     <= req_set;
                        way_q     <= req_way;
                        sweep_idx <= '0;
                        req_ready <= 1'b0;
                        state     <= (req_op == OP_CLEAR) ? S_SWEEP : S_READ;
                    end
                end
                S_READ: begin
                    // Response is registered here so it is visible during UPDATE.
                    nxt_age    <= c_age;
                    nxt_valid  <= c_valid;
                    resp_valid <= 1'b1;
                    resp_way   <= c_way;
                    resp_evict <= c_evict;
                    resp_err   <= c_err;
`ifdef LRU_STATS_EN
                    if (op_q == OP_TOUCH && !c_err) stat_touch <= sat_inc(stat_touch);
                    if (op_q == OP_ALLOC) begin
                        stat_alloc <= sat_inc(stat_alloc);
                        if (c_evict) stat_evict <= sat_inc(stat_evict);
                    end
`endif
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                S_SWEEP: begin
                    // Pulse lands in the cycle that rewrites the last set.
                    if (sweep_idx == SET_BITS'(NUM_SETS - 2)) begin
                        resp_valid <= 1'b1;
                        resp_way   <= 2'd0;
                        resp_evict <= 1'b0;
                        resp_err   <= 1'b0;
                    end
                    if (sweep_idx == SET_BITS'(NUM_SETS - 1)) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
`ifdef LRU_STATS_EN
                        stat_touch <= 32'd0;
                        stat_alloc <= 32'd0;
                        stat_evict <= 32'd0;
`endif
                    end
                    sweep_idx <= sweep_idx + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Age/valid storage: written back in UPDATE, reinitialised set by set in SWEEP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                age_mem[s]   <= AGE_INIT;
                valid_mem[s] <= 4'd0;
            end
        end else if (state == S_UPDATE) begin
            age_mem[set_q]   <= nxt_age;
            valid_mem[set_q] <= nxt_valid;
        end else if (state == S_SWEEP) begin
            age_mem[sweep_idx]   <= AGE_INIT;
            valid_mem[sweep_idx] <= 4'd0;
        end
    end

endmodule

// File: tb/tb_lru_set_ctrl.sv
// tb_lru_set_ctrl: scoreboard bench for lru_set_ctrl (SET_BITS = 6).
// The reference model keeps each set as a recency list (MRU first); a way's
// age is its position in that list. Expected responses, including the cycle
// they must appear in, are queued when a request is driven.
module tb_lru_set_ctrl;

    localparam int SET_BITS = 6;
    localparam int NUM_SETS = 64;
    localparam int W        = 36;

    localparam logic [1:0] OP_TOUCH = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [1:0]          req_op = 2'b00;
    logic [SET_BITS-1:0] req_set = '0;
    logic [1:0]          req_way = 2'b00;
    logic                resp_valid;
    logic [1:0]          resp_way;
    logic                resp_evict;
    logic                resp_err;
    logic [1:0]          dbg_state;
`ifdef LRU_STATS_EN
    logic [31:0]         stat_touch;
    logic [31:0]         stat_alloc;
    logic [31:0]         stat_evict;
`endif

    lru_set_ctrl #(.SET_BITS(SET_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_set    (req_set),
        .req_way    (req_way),
        .resp_valid (resp_valid),
        .resp_way   (resp_way),
        .resp_evict (resp_evict),
        .resp_err   (resp_err),
        .dbg_state  (dbg_state)
`ifdef LRU_STATS_EN
        ,
        .stat_touch (stat_touch),
        .stat_alloc (stat_alloc),
        .stat_evict (stat_evict)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_order [NUM_SETS][4];
    logic [3:0]  m_valid [NUM_SETS];
    int unsigned m_touch, m_alloc, m_evict;

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int p = 0; p < 4; p++) m_order[s][p] = p;
            m_valid[s] = 4'd0;
        end
        m_touch = 0;
        m_alloc = 0;
        m_evict = 0;
    endfunction

    function automatic int m_age(input int s, input int w);
        for (int p = 0; p < 4; p++) if (m_order[s][p] == w) return p;
        return -1;
    endfunction

    function automatic void m_to_front(input int s, input int w);
        int p;
        p = m_age(s, w);
        for (int q = p; q > 0; q--) m_order[s][q] = m_order[s][q-1];
        m_order[s][0] = w;
    endfunction

    function automatic void m_to_back(input int s, input int w);
        int p;
        p = m_age(s, w);
        for (int q = p; q < 3; q++) m_order[s][q] = m_order[s][q+1];
        m_order[s][3] = w;
    endfunction

    function automatic logic [1:0] dut_age(input int s, input int w);
        logic [7:0] a;
        a = dut.age_mem[s];
        return a[2*w +: 2];
    endfunction

    // ---------------- scoreboard ----------------
    // Entry: {expected cycle[31:0], err, evict, way[1:0]}
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_resp", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("resp_cycle", cyc, e[35:4]);
                check("resp_way", {30'd0, resp_way}, {30'd0, e[1:0]});
                check("resp_evict", {31'd0, resp_evict}, {31'd0, e[2]});
                check("resp_err", {31'd0, resp_err}, {31'd0, e[3]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(output bit ok);
        int guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ok = req_ready;
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input int s, input int w);
        bit         ok;
        logic       e_err, e_evict;
        logic [1:0] e_way;
        int unsigned lat;
        @(negedge clk);
        wait_ready(ok);
        if (!ok) return;
        e_err   = 1'b0;
        e_evict = 1'b0;
        e_way   = 2'(w);
        lat     = 2;
        case (op)
            OP_TOUCH: begin
                if (m_valid[s][w]) begin
                    m_to_front(s, w);
                    m_touch++;
                end else e_err = 1'b1;
            end
            OP_ALLOC: begin
                int v = -1;
                for (int i = 0; i < 4; i++) if (v < 0 && !m_valid[s][i]) v = i;
                if (v < 0) begin
                    v = m_order[s][3];
                    e_evict = 1'b1;
                    m_evict++;
                end
                m_alloc++;
                m_valid[s][v] = 1'b1;
                m_to_front(s, v);
                e_way = 2'(v);
            end
            OP_INVAL: begin
                if (m_valid[s][w]) begin
                    m_to_back(s, w);
                    m_valid[s][w] = 1'b0;
                end else e_err = 1'b1;
            end
            default: begin
                model_reset();
                e_way = 2'd0;
                lat   = NUM_SETS;
            end
        endcase
        exp_q.push_back({cyc + lat, e_err, e_evict, e_way});
        req_valid = 1'b1;
        req_op    = op;
        req_set   = SET_BITS'(s);
        req_way   = 2'(w);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_set_ages(input string tag, input int s, input int a0, input int a1,
                                  input int a2, input int a3);
        check({tag, "_w0"}, {30'd0, dut_age(s, 0)}, a0);
        check({tag, "_w1"}, {30'd0, dut_age(s, 1)}, a1);
        check({tag, "_w2"}, {30'd0, dut_age(s, 2)}, a2);
        check({tag, "_w3"}, {30'd0, dut_age(s, 3)}, a3);
    endtask

    task automatic apply_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok;
        int low;

        model_reset();
        apply_reset();

        // reset state
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_way", {30'd0, resp_way}, 32'd0);
        check("rst_resp_evict", {31'd0, resp_evict}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check_set_ages("rst_age", 5, 0, 1, 2, 3);

        // fill set 5: ways 0..3, no evictions
        for (int i = 0; i < 4; i++) send(OP_ALLOC, 5, 0);
        drain();
        check_set_ages("fill_age", 5, 3, 2, 1, 0);

        // touch way 0 then allocate: way 1 is LRU and gets evicted
        send(OP_TOUCH, 5, 0);
        send(OP_ALLOC, 5, 0);
        drain();
        check_set_ages("evict_age", 5, 1, 0, 3, 2);

        // invalidate way 2, touch it (error, no change), then reallocate it
        send(OP_INVAL, 5, 2);
        send(OP_TOUCH, 5, 2);
        drain();
        check_set_ages("err_age", 5, 1, 0, 3, 2);
        send(OP_ALLOC, 5, 0);
        send(OP_INVAL, 7, 1);
        drain();

        // CLEAR: ready low for NUM_SETS cycles, response on the last one
        send(OP_CLEAR, 0, 0);
        low = 0;
        while (!req_ready && low < 200) begin
            low++;
            @(negedge clk);
        end
        check("clear_ready_low", low, NUM_SETS);
        drain();
        check_set_ages("clear_age", 5, 0, 1, 2, 3);
        send(OP_ALLOC, 17, 0);
        send(OP_ALLOC, 5, 0);
        drain();

        // reset during READ of an ALLOC: no response, set back to reset ages
        @(negedge clk);
        wait_ready(ok);
        req_valid = 1'b1;
        req_op    = OP_ALLOC;
        req_set   = SET_BITS'(5);
        req_way   = 2'd0;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_state_read", {30'd0, dbg_state}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("mid_ready", {31'd0, req_ready}, 32'd1);
        check_set_ages("mid_age", 5, 0, 1, 2, 3);
        send(OP_ALLOC, 5, 0);
        drain();

`ifdef LRU_STATS_EN
        // 3 touches, 5 allocations with exactly one eviction
        send(OP_CLEAR, 0, 0);
        drain();
        for (int i = 0; i < 4; i++) send(OP_ALLOC, 9, 0);
        for (int i = 0; i < 3; i++) send(OP_TOUCH, 9, i);
        send(OP_ALLOC, 9, 0);
        drain();
        check("stat_touch", stat_touch, 32'd3);
        check("stat_alloc", stat_alloc, 32'd5);
        check("stat_evict", stat_evict, 32'd1);
`endif

        // random traffic on a few sets
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 59) == 0) send(OP_CLEAR, 0, 0);
            else send(2'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        drain();
        for (int s = 0; s < 4; s++) begin
            logic [3:0] seen;
            seen = 4'd0;
            for (int w = 0; w < 4; w++) begin
                seen[dut_age(s, w)] = 1'b1;
                check("rand_age", {30'd0, dut_age(s, w)}, m_age(s, w));
            end
            check("rand_perm", {28'd0, seen}, 32'hF);
            check("rand_valid", {28'd0, dut.valid_mem[s]}, {28'd0, m_valid[s]});
        end
`ifdef LRU_STATS_EN
        check("rand_stat_touch", stat_touch, m_touch);
        check("rand_stat_alloc", stat_alloc, m_alloc);
        check("rand_stat_evict", stat_evict, m_evict);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
